// File: rtl/seq_divider_16by8.sv
// -----------------------------------------------------------------------------
// seq_divider_16by8
//
// Sequential restoring divider: 16-bit unsigned dividend divided by an 8-bit
// unsigned divisor, producing a 16-bit quotient and an 8-bit remainder.
// One quotient bit is resolved per clock, so a normal division takes 16 RUN
// cycles plus one DONE cycle. This is the inverse-direction companion of the
// 8x16 Wallace-tree multiplier. Its results are used to cross-check products
// and to normalise operands.
//
// Handshake: start is sampled only in IDLE. busy is high while the operation
// runs. done pulses for one cycle when quotient/remainder/dbz are valid. The
// results then hold until the next completed operation.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous, active-low reset
//   start      in   1   begin a division (ignored unless IDLE)
//   dividend   in  16   unsigned dividend, captured on accepted start
//   divisor    in   8   unsigned divisor, captured on accepted start
//   busy       out  1   operation in progress
//   done       out  1   one-cycle result-valid pulse
//   quotient   out 16   unsigned quotient (registered)
//   remainder  out  8   unsigned remainder (registered)
//   dbz        out  1   divide-by-zero flag, valid with done
//
// Configuration macro: DIV_DBZ_CHECK_EN
//   Defined:
//     A zero divisor goes straight from IDLE to DONE.
//     It returns quotient=16'hFFFF, remainder=0 and dbz=1.
//     busy is held high for that single DONE cycle.
//   Undefined:
//     dbz is tied low.
//     A zero divisor runs the normal 16 iterations.
//     That gives quotient=16'hFFFF and remainder=dividend[7:0].
// -----------------------------------------------------------------------------
module seq_divider_16by8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers.
  // shift_q starts as the dividend. Each iteration shifts its MSB into the
  // partial remainder and shifts the new quotient bit in at the LSB, so after
  // 16 iterations it holds the quotient.
  logic [15:0] shift_q;
  logic [7:0]  divisor_q;
  logic [3:0]  count;

  // The partial remainder is conceptually 9 bits wide. After the
  // restore/keep decision it is always below the divisor, so its top bit is
  // always zero and is not stored. The 9-bit value exists only as trial_rem.
  logic [7:0]  part_rem;

  logic [15:0] quot_q;
  logic [7:0]  rem_q;

  // Combinational single-iteration datapath.
  logic [8:0]  trial_rem;
  logic        q_bit;
  logic [7:0]  rem_next;
  logic [15:0] shift_next;

`ifdef DIV_DBZ_CHECK_EN
  logic        dbz_q;
  logic        div_zero;

  assign div_zero = (divisor == 8'h00);
`endif

  // One restoring step.
  // The 9-bit trial value is compared against the divisor; no borrow means
  // quotient bit 1. When it succeeds, the true difference is below the
  // divisor, so the low 8 bits of the subtraction are exact.
  always_comb begin
    trial_rem  = {part_rem, shift_q[15]};
    q_bit      = (trial_rem >= {1'b0, divisor_q});
    rem_next   = trial_rem[7:0];
    if (q_bit) begin
      rem_next = trial_rem[7:0] - divisor_q;
    end
    shift_next = {shift_q[14:0], q_bit};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_DBZ_CHECK_EN
          state_next = div_zero ? DONE : RUN;
`else
          state_next = RUN;
`endif
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == 4'd0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
`ifdef DIV_DBZ_CHECK_EN
        // The short zero-divisor path still shows one busy cycle.
        busy       = dbz_q;
`endif
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers.
  // Operands are captured on acceptance. The iteration runs in RUN. Results
  // are written only on the final iteration, so they hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= 16'h0000;
      divisor_q <= 8'h00;
      part_rem  <= 8'h00;
      count     <= 4'd0;
      quot_q    <= 16'h0000;
      rem_q     <= 8'h00;
`ifdef DIV_DBZ_CHECK_EN
      dbz_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_q   <= dividend;
            divisor_q <= divisor;
            part_rem  <= 8'h00;
            count     <= 4'd15;
`ifdef DIV_DBZ_CHECK_EN
            if (div_zero) begin
              quot_q <= 16'hFFFF;
              rem_q  <= 8'h00;
              dbz_q  <= 1'b1;
            end
`endif
          end
        end
        RUN: begin
          shift_q  <= shift_next;
          part_rem <= rem_next;
          count    <= count - 4'd1;
          if (count == 4'd0) begin
            quot_q <= shift_next;
            rem_q  <= rem_next;
`ifdef DIV_DBZ_CHECK_EN
            dbz_q  <= 1'b0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;

`ifdef DIV_DBZ_CHECK_EN
  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

endmodule
